// File: rtl/tetris_pkg.sv
// tetris_pkg: playfield geometry, row type, clear-engine states and line-score table.
package tetris_pkg;
    localparam int GRID_COLS = 10;
    localparam int GRID_ROWS = 18;
    localparam int ROW_AW = $clog2(GRID_ROWS);
    localparam int CNT_W = $clog2(GRID_ROWS + 1);
    typedef logic [GRID_COLS-1:0] row_t;
    typedef enum logic [2:0] {IDLE, RD, EVAL, FILL, DONE} lc_state_t;
    localparam logic [4:0][15:0] SCORE_LUT = {16'd1200, 16'd300, 16'd100, 16'd40, 16'd0};
endpackage

// File: rtl/line_clear_engine_if.sv
// line_clear_engine_if: one-read-port / one-write-port row store bus.
interface line_clear_engine_if;
    import tetris_pkg::*;
    logic [ROW_AW-1:0] row_rd_addr;
    row_t              row_rd_data;
    logic              row_wr_en;
    logic [ROW_AW-1:0] row_wr_addr;
    row_t              row_wr_data;
    modport master(output row_rd_addr, row_wr_en, row_wr_addr, row_wr_data, input row_rd_data);
    modport slave(input row_rd_addr, row_wr_en, row_wr_addr, row_wr_data, output row_rd_data);
endinterface

// File: rtl/line_score_lut.sv
// line_score_lut: cleared-line count to points; exists only when LINE_CLEAR_SCORE_EN is defined.
`ifdef LINE_CLEAR_SCORE_EN
module line_score_lut import tetris_pkg::*; (
    input  logic [CNT_W-1:0] cnt,
    output logic [15:0]      points
);
    assign points = (cnt > CNT_W'(4)) ? SCORE_LUT[4] : SCORE_LUT[cnt[2:0]];
endmodule
`endif

// File: rtl/line_clear_engine.sv
// line_clear_engine: removes full rows bottom-up, compacts the grid downward and zero-fills the top.
// Optional running score enabled by LINE_CLEAR_SCORE_EN.
module line_clear_engine import tetris_pkg::*; (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   lines_cleared,
    output logic [15:0]        score,
    line_clear_engine_if.master mem
);
    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_RD   = RD;
    localparam logic [2:0] S_EVAL = EVAL;
    localparam logic [2:0] S_FILL = FILL;
    localparam logic [2:0] S_DONE = DONE;

    logic [2:0]        state;
    logic [ROW_AW-1:0] r, w;
    logic [CNT_W-1:0]  cnt;
    logic              full;

    assign full = &mem.row_rd_data;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= S_IDLE;
            r             <= '0;
            w             <= '0;
            cnt           <= '0;
            lines_cleared <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    r     <= ROW_AW'(GRID_ROWS - 1);
                    w     <= ROW_AW'(GRID_ROWS - 1);
                    cnt   <= '0;
                    state <= S_RD;
                end
                S_RD: state <= S_EVAL;
                S_EVAL: begin
                    if (full) cnt <= cnt + 1'b1;
                    else w <= w - 1'b1;
                    if (r == '0) state <= (full || cnt != '0) ? S_FILL : S_DONE;
                    else begin
                        r     <= r - 1'b1;
                        state <= S_RD;
                    end
                end
                S_FILL: begin
                    if (w == '0) state <= S_DONE;
                    else w <= w - 1'b1;
                end
                S_DONE: begin
                    lines_cleared <= cnt;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Compaction writes only when a hole has opened below (w != r); read data is valid in EVAL.
    assign busy            = state != S_IDLE;
    assign done            = state == S_DONE;
    assign mem.row_rd_addr = r;
    assign mem.row_wr_en   = (state == S_EVAL && !full && w != r) || state == S_FILL;
    assign mem.row_wr_addr = mem.row_wr_en ? w : '0;
    assign mem.row_wr_data = (state == S_EVAL && mem.row_wr_en) ? mem.row_rd_data : '0;

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] points;
    logic [16:0] sum;

    line_score_lut u_lut (.cnt(cnt), .points(points));

    assign sum = {1'b0, score} + {1'b0, points};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) score <= '0;
        else if (state == S_DONE) score <= sum[16] ? 16'hFFFF : sum[15:0];
    end
`else
    assign score = 16'd0;
`endif
endmodule

// File: tb/tb_line_clear_engine.sv
// tb_line_clear_engine: directed passes over a behavioural row store with a result scoreboard.
module tb_line_clear_engine;
    import tetris_pkg::*;

    typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0] grid_t;
    typedef struct packed {
        grid_t       g;
        logic [31:0] lines;
        logic [31:0] writes;
        logic [31:0] lat;
        logic [31:0] score;
    } exp_t;

    logic             clk = 0;
    logic             rst = 1;
    logic             start = 0;
    logic             busy, done;
    logic [CNT_W-1:0] lines_cleared;
    logic [15:0]      score;
    line_clear_engine_if mem();

    line_clear_engine dut (
        .Clk(clk), .Reset(rst), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .score(score), .mem(mem)
    );

    always #5 clk = ~clk;

    grid_t grid;
    grid_t preload;
    logic  do_load = 0;
    int    wr_count = 0;
    int    done_count = 0;

    always @(posedge clk) begin
        mem.row_rd_data <= (int'(mem.row_rd_addr) < GRID_ROWS) ? grid[mem.row_rd_addr] : '0;
        if (do_load) grid <= preload;
        else if (mem.row_wr_en && int'(mem.row_wr_addr) < GRID_ROWS) grid[mem.row_wr_addr] <= mem.row_wr_data;
        if (mem.row_wr_en) wr_count <= wr_count + 1;
        if (done) done_count <= done_count + 1;
    end

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   exp_score = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int points(input int c);
        if (c == 0) return 0;
        if (c == 1) return 40;
        if (c == 2) return 100;
        if (c == 3) return 300;
        return 1200;
    endfunction

    task automatic model(output exp_t e);
        grid_t ng = '0;
        int wr = GRID_ROWS - 1;
        int c = 0;
        int wrs = 0;
        for (int i = GRID_ROWS - 1; i >= 0; i--) begin
            if (&grid[i]) c++;
            else begin
                ng[wr] = grid[i];
                if (wr != i) wrs++;
                wr--;
            end
        end
`ifdef LINE_CLEAR_SCORE_EN
        exp_score = (exp_score + points(c) > 32'hFFFF) ? 32'hFFFF : exp_score + points(c);
`endif
        e.g = ng;
        e.lines = c;
        e.writes = wrs + c;
        e.lat = 2 * GRID_ROWS + c + 1;
        e.score = exp_score;
    endtask

    task automatic load(input grid_t g);
        preload = g;
        do_load = 1;
        @(posedge clk);
        #1 do_load = 0;
    endtask

    task automatic run_pass(input bit glitch, input bit abort);
        exp_t e;
        int   n, w0, d0;
        bit   aborted = 0;
        model(e);
        sb.push_back(e);
        w0 = wr_count;
        d0 = done_count;
        @(posedge clk);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
        n = 1;
        check("busy_after_start", busy, 1);
        while (!done && n < 200 && !aborted) begin
            if (glitch && n == 5) start = 1;
            if (glitch && n == 6) start = 0;
            if (abort && n == 2 * GRID_ROWS + 1) begin
                check("fill_wr_en", mem.row_wr_en, 1);
                rst = 1;
                #1;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_wr_en", mem.row_wr_en, 0);
                check("abort_wr_addr", mem.row_wr_addr, 0);
                check("abort_wr_data", mem.row_wr_data, 0);
                check("abort_rd_addr", mem.row_rd_addr, 0);
                check("abort_lines", lines_cleared, 0);
                check("abort_score", score, 0);
                void'(sb.pop_back());
                exp_score = 0;
                #2 rst = 0;
                aborted = 1;
            end else begin
                @(posedge clk);
                #1 n++;
            end
        end
        if (!aborted) begin
            check("done_seen", done, 1);
            e = sb.pop_front();
            check("latency", n, e.lat);
            @(posedge clk);
            #1;
            check("done_single", done, 0);
            check("busy_end", busy, 0);
            check("lines_cleared", lines_cleared, e.lines);
            check("score", score, e.score);
            check("write_count", wr_count - w0, e.writes);
            check("done_count", done_count - d0, 1);
            for (int i = 0; i < GRID_ROWS; i++) check($sformatf("row%0d", i), grid[i], e.g[i]);
        end
    endtask

    initial begin
        grid_t g;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", mem.row_wr_en, 0);
        check("rst_wr_addr", mem.row_wr_addr, 0);
        check("rst_wr_data", mem.row_wr_data, 0);
        check("rst_rd_addr", mem.row_rd_addr, 0);
        check("rst_lines", lines_cleared, 0);
        check("rst_score", score, 0);
        #20 rst = 0;
        load('0);
        run_pass(0, 0);
        g = '0;
        g[17] = '1;
        g[16] = 10'h001;
        load(g);
        run_pass(0, 0);
        g = '0;
        for (int i = 14; i < 18; i++) g[i] = '1;
        g[13] = 10'h3F0;
        load(g);
        run_pass(0, 0);
        g = '0;
        g[17] = '1;
        g[16] = 10'h00A;
        g[15] = '1;
        g[14] = 10'h00B;
        g[13] = 10'h155;
        g[0]  = 10'h201;
        load(g);
        run_pass(0, 0);
        load(g);
        run_pass(1, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < GRID_ROWS; i++) g[i] = ($urandom_range(0, 2) == 0) ? '1 : GRID_COLS'($urandom);
            load(g);
            run_pass(0, 0);
        end
        load('1);
        run_pass(0, 1);
        load('1);
        run_pass(0, 0);
        for (int k = 0; k < 56; k++) begin
            load('1);
            run_pass(0, 0);
        end
`ifdef LINE_CLEAR_SCORE_EN
        check("score_saturated", score, 16'hFFFF);
`else
        check("score_disabled", score, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
